// File: rtl/huffman_table_sequencer_pkg.sv
// Shared definitions for the DEFLATE Huffman table setup sequencer:
// state encoding, block-type codes and the fixed-table length boundaries.
package huffman_table_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FIXED = 3'd1,
      ST_LOAD  = 3'd2,
      ST_PAD   = 3'd3,
      ST_BUILD = 3'd4,
      ST_READY = 3'd5
   } state_t;

   localparam logic [1:0] BTYPE_FIXED = 2'd1;
   localparam logic [1:0] BTYPE_DYN   = 2'd2;

   localparam logic [8:0] FIXED_BND_0    = 9'd144;
   localparam logic [8:0] FIXED_BND_1    = 9'd256;
   localparam logic [8:0] FIXED_BND_2    = 9'd280;
   localparam logic [3:0] FIXED_DIST_LEN = 4'd5;

   localparam logic [8:0] HLIT_MIN  = 9'd257;
   localparam logic [8:0] HLIT_MAX  = 9'd286;
   localparam logic [5:0] HDIST_MIN = 6'd1;
   localparam logic [5:0] HDIST_MAX = 6'd30;

   function automatic logic dyn_params_ok(input logic [8:0] hlit, input logic [5:0] hdist);
      return (hlit >= HLIT_MIN) && (hlit <= HLIT_MAX) &&
             (hdist >= HDIST_MIN) && (hdist <= HDIST_MAX);
   endfunction

endpackage

// File: rtl/huffman_table_sequencer_fixed_len_rom.sv
// Fixed-Huffman literal/length code length lookup (address -> length).
module huffman_table_sequencer_fixed_len_rom
   import huffman_table_sequencer_pkg::*;
(
   input  logic [8:0] addr,
   output logic [3:0] len
);

   // Piecewise-constant length table of the fixed literal/length code.
   always_comb begin
      if (addr < FIXED_BND_0) begin
         len = 4'd8;
      end else if (addr < FIXED_BND_1) begin
         len = 4'd9;
      end else if (addr < FIXED_BND_2) begin
         len = 4'd7;
      end else begin
         len = 4'd8;
      end
   end

endmodule

// File: rtl/huffman_table_sequencer.sv
// Sequences code-length writes into the lit/len and distance table builders,
// for fixed or dynamic blocks, then runs the builders until both report done.
module huffman_table_sequencer
   import huffman_table_sequencer_pkg::*;
#(
   parameter int LITCODES  = 288,
   parameter int DISTCODES = 32,
   parameter int CODEBITS  = 5
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                start,
   input  logic [1:0]          btype,
   input  logic [8:0]          hlit,
   input  logic [5:0]          hdist,
   input  logic                len_valid,
   output logic                len_ready,
   input  logic [3:0]          len_data,
   input  logic                abort,
   input  logic                block_end,
   output logic                busy,
   output logic                tables_ready,
   output logic                err,
   output logic                lit_wren,
   output logic [8:0]          lit_wraddr,
   output logic [CODEBITS-1:0] lit_wrdata,
   output logic                lit_run,
   input  logic                lit_done,
   output logic                dist_wren,
   output logic [4:0]          dist_wraddr,
   output logic [CODEBITS-1:0] dist_wrdata,
   output logic                dist_run,
   input  logic                dist_done
);

   localparam logic [8:0] LIT_LAST  = 9'(LITCODES - 1);
   localparam logic [5:0] DIST_LAST = 6'(DISTCODES - 1);
   localparam logic [8:0] DIST_CNT9 = 9'(DISTCODES);

   state_t              state_r, next_state_s;
   logic [8:0]          hlit_r, next_hlit_s;
   logic [5:0]          hdist_r, next_hdist_s;
   logic [8:0]          lit_ptr_r, next_lit_ptr_s;
   logic [5:0]          dist_ptr_r, next_dist_ptr_s;
   logic [8:0]          xfer_cnt_r, next_xfer_cnt_s;
   logic                lit_done_l_r, next_lit_done_l_s;
   logic                dist_done_l_r, next_dist_done_l_s;
   logic                len_ready_r, next_len_ready_s;
   logic                busy_r, next_busy_s;
   logic                tables_ready_r, next_tables_ready_s;
   logic                err_r, next_err_s;
   logic                run_r, next_run_s;
   logic                lit_wren_r, next_lit_wren_s;
   logic [8:0]          lit_wraddr_r, next_lit_wraddr_s;
   logic [CODEBITS-1:0] lit_wrdata_r, next_lit_wrdata_s;
   logic                dist_wren_r, next_dist_wren_s;
   logic [4:0]          dist_wraddr_r, next_dist_wraddr_s;
   logic [CODEBITS-1:0] dist_wrdata_r, next_dist_wrdata_s;
   logic [8:0]          rom_addr_s;
   logic [3:0]          rom_len_s;
   logic [8:0]          last_idx_s;

   // Entering FIXED from IDLE issues address 0, so the ROM sees 0 outside FIXED.
   assign rom_addr_s = (state_r == ST_FIXED) ? lit_ptr_r : 9'd0;
   assign last_idx_s = hlit_r + 9'(hdist_r) - 9'd1;

   huffman_table_sequencer_fixed_len_rom u_fixed_len_rom (
      .addr (rom_addr_s),
      .len  (rom_len_s)
   );

   // Next-state and next-output decode; every output is registered from here,
   // so writes and run appear in the same cycle as the state that owns them.
   always_comb begin
      next_state_s        = state_r;
      next_hlit_s         = hlit_r;
      next_hdist_s        = hdist_r;
      next_lit_ptr_s      = lit_ptr_r;
      next_dist_ptr_s     = dist_ptr_r;
      next_xfer_cnt_s     = xfer_cnt_r;
      next_lit_done_l_s   = lit_done_l_r;
      next_dist_done_l_s  = dist_done_l_r;
      next_len_ready_s    = 1'b0;
      next_busy_s         = 1'b0;
      next_tables_ready_s = 1'b0;
      next_err_s          = 1'b0;
      next_run_s          = 1'b0;
      next_lit_wren_s     = 1'b0;
      next_lit_wraddr_s   = lit_wraddr_r;
      next_lit_wrdata_s   = lit_wrdata_r;
      next_dist_wren_s    = 1'b0;
      next_dist_wraddr_s  = dist_wraddr_r;
      next_dist_wrdata_s  = dist_wrdata_r;

      if (abort) begin
         next_state_s       = ST_IDLE;
         next_lit_ptr_s     = 9'd0;
         next_dist_ptr_s    = 6'd0;
         next_xfer_cnt_s    = 9'd0;
         next_lit_done_l_s  = 1'b0;
         next_dist_done_l_s = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               next_lit_ptr_s     = 9'd0;
               next_dist_ptr_s    = 6'd0;
               next_xfer_cnt_s    = 9'd0;
               next_lit_done_l_s  = 1'b0;
               next_dist_done_l_s = 1'b0;
               if (start) begin
                  next_hlit_s  = hlit;
                  next_hdist_s = hdist;
                  if (btype == BTYPE_FIXED) begin
                     next_state_s       = ST_FIXED;
                     next_lit_ptr_s     = 9'd1;
                     next_lit_wren_s    = 1'b1;
                     next_lit_wraddr_s  = 9'd0;
                     next_lit_wrdata_s  = CODEBITS'(rom_len_s);
                     next_dist_wren_s   = 1'b1;
                     next_dist_wraddr_s = 5'd0;
                     next_dist_wrdata_s = CODEBITS'(FIXED_DIST_LEN);
                  end else if ((btype == BTYPE_DYN) && dyn_params_ok(hlit, hdist)) begin
                     next_state_s     = ST_LOAD;
                     next_len_ready_s = 1'b1;
                  end else begin
                     next_err_s = 1'b1;
                  end
               end else begin
                  next_state_s = ST_IDLE;
               end
            end
            ST_FIXED: begin
               if (lit_ptr_r <= LIT_LAST) begin
                  next_lit_wren_s   = 1'b1;
                  next_lit_wraddr_s = lit_ptr_r;
                  next_lit_wrdata_s = CODEBITS'(rom_len_s);
                  next_lit_ptr_s    = lit_ptr_r + 9'd1;
                  if (lit_ptr_r < DIST_CNT9) begin
                     next_dist_wren_s   = 1'b1;
                     next_dist_wraddr_s = 5'(lit_ptr_r);
                     next_dist_wrdata_s = CODEBITS'(FIXED_DIST_LEN);
                  end else begin
                     next_dist_wren_s = 1'b0;
                  end
               end else begin
                  next_state_s   = ST_BUILD;
                  next_run_s     = 1'b1;
                  next_lit_ptr_s = 9'd0;
               end
            end
            ST_LOAD: begin
               next_len_ready_s = 1'b1;
               if (len_valid && len_ready_r) begin
                  if (xfer_cnt_r < hlit_r) begin
                     next_lit_wren_s   = 1'b1;
                     next_lit_wraddr_s = xfer_cnt_r;
                     next_lit_wrdata_s = CODEBITS'(len_data);
                  end else begin
                     next_dist_wren_s   = 1'b1;
                     next_dist_wraddr_s = 5'(xfer_cnt_r - hlit_r);
                     next_dist_wrdata_s = CODEBITS'(len_data);
                  end
                  next_xfer_cnt_s = xfer_cnt_r + 9'd1;
                  if (xfer_cnt_r == last_idx_s) begin
                     next_state_s     = ST_PAD;
                     next_len_ready_s = 1'b0;
                     next_lit_ptr_s   = hlit_r;
                     next_dist_ptr_s  = hdist_r;
                  end else begin
                     next_state_s = ST_LOAD;
                  end
               end else begin
                  next_state_s = ST_LOAD;
               end
            end
            ST_PAD: begin
               if (lit_ptr_r <= LIT_LAST) begin
                  next_lit_wren_s   = 1'b1;
                  next_lit_wraddr_s = lit_ptr_r;
                  next_lit_wrdata_s = {CODEBITS{1'b0}};
                  next_lit_ptr_s    = lit_ptr_r + 9'd1;
               end else begin
                  next_lit_wren_s = 1'b0;
               end
               if (dist_ptr_r <= DIST_LAST) begin
                  next_dist_wren_s   = 1'b1;
                  next_dist_wraddr_s = 5'(dist_ptr_r);
                  next_dist_wrdata_s = {CODEBITS{1'b0}};
                  next_dist_ptr_s    = dist_ptr_r + 6'd1;
               end else begin
                  next_dist_wren_s = 1'b0;
               end
               // Leave only once nothing is left to issue, so no write lands in BUILD.
               if ((lit_ptr_r > LIT_LAST) && (dist_ptr_r > DIST_LAST)) begin
                  next_state_s    = ST_BUILD;
                  next_run_s      = 1'b1;
                  next_lit_ptr_s  = 9'd0;
                  next_dist_ptr_s = 6'd0;
               end else begin
                  next_state_s = ST_PAD;
               end
            end
            ST_BUILD: begin
               next_run_s         = 1'b1;
               next_lit_done_l_s  = lit_done_l_r | lit_done;
               next_dist_done_l_s = dist_done_l_r | dist_done;
               if (next_lit_done_l_s && next_dist_done_l_s) begin
                  next_state_s        = ST_READY;
                  next_tables_ready_s = 1'b1;
               end else begin
                  next_state_s = ST_BUILD;
               end
            end
            ST_READY: begin
               if (block_end) begin
                  next_state_s       = ST_IDLE;
                  next_lit_done_l_s  = 1'b0;
                  next_dist_done_l_s = 1'b0;
               end else begin
                  next_run_s          = 1'b1;
                  next_tables_ready_s = 1'b1;
               end
            end
            default: begin
               next_state_s = ST_IDLE;
            end
         endcase
      end
      next_busy_s = (next_state_s != ST_IDLE);
   end

   // State, counters, done latches and all registered outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r        <= ST_IDLE;
         hlit_r         <= 9'd0;
         hdist_r        <= 6'd0;
         lit_ptr_r      <= 9'd0;
         dist_ptr_r     <= 6'd0;
         xfer_cnt_r     <= 9'd0;
         lit_done_l_r   <= 1'b0;
         dist_done_l_r  <= 1'b0;
         len_ready_r    <= 1'b0;
         busy_r         <= 1'b0;
         tables_ready_r <= 1'b0;
         err_r          <= 1'b0;
         run_r          <= 1'b0;
         lit_wren_r     <= 1'b0;
         lit_wraddr_r   <= 9'd0;
         lit_wrdata_r   <= {CODEBITS{1'b0}};
         dist_wren_r    <= 1'b0;
         dist_wraddr_r  <= 5'd0;
         dist_wrdata_r  <= {CODEBITS{1'b0}};
      end else begin
         state_r        <= next_state_s;
         hlit_r         <= next_hlit_s;
         hdist_r        <= next_hdist_s;
         lit_ptr_r      <= next_lit_ptr_s;
         dist_ptr_r     <= next_dist_ptr_s;
         xfer_cnt_r     <= next_xfer_cnt_s;
         lit_done_l_r   <= next_lit_done_l_s;
         dist_done_l_r  <= next_dist_done_l_s;
         len_ready_r    <= next_len_ready_s;
         busy_r         <= next_busy_s;
         tables_ready_r <= next_tables_ready_s;
         err_r          <= next_err_s;
         run_r          <= next_run_s;
         lit_wren_r     <= next_lit_wren_s;
         lit_wraddr_r   <= next_lit_wraddr_s;
         lit_wrdata_r   <= next_lit_wrdata_s;
         dist_wren_r    <= next_dist_wren_s;
         dist_wraddr_r  <= next_dist_wraddr_s;
         dist_wrdata_r  <= next_dist_wrdata_s;
      end
   end

   assign len_ready    = len_ready_r;
   assign busy         = busy_r;
   assign tables_ready = tables_ready_r;
   assign err          = err_r;
   assign lit_wren     = lit_wren_r;
   assign lit_wraddr   = lit_wraddr_r;
   assign lit_wrdata   = lit_wrdata_r;
   assign lit_run      = run_r;
   assign dist_wren    = dist_wren_r;
   assign dist_wraddr  = dist_wraddr_r;
   assign dist_wrdata  = dist_wrdata_r;
   assign dist_run     = run_r;

endmodule
